// File: rtl/pattern_counter.sv
// Counts occurrences of a PAT_W-bit pattern in a NUM_BYTES string held in memory and writes the counts back.
// Define PATCNT_CROSS_EN to add cross-byte (bitstream) counting, CntStream and the third result write.
module pattern_counter #(
    parameter int unsigned NUM_BYTES = 32,
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned PAT_W     = 5,
    localparam int unsigned ADDR_W   = $clog2(NUM_BYTES + 4),
    localparam int unsigned CNT_W    = $clog2(NUM_BYTES * BYTE_W + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    output logic              Ack,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [BYTE_W-1:0] MemRdData,
    output logic              MemWrEn,
    output logic [BYTE_W-1:0] MemWrData,
    output logic [CNT_W-1:0]  CntByte,
    output logic [CNT_W-1:0]  CntOcc,
    output logic [CNT_W-1:0]  CntStream
);

    localparam int unsigned HIT_W = $clog2(BYTE_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_PAT,
        SCAN,
        DRAIN,
        WR_BYTE,
        WR_OCC,
`ifdef PATCNT_CROSS_EN
        WR_STR,
`endif
        DONE
    } state_t;

    state_t             state;
    logic [PAT_W-1:0]   pat_q;
    logic [HIT_W-1:0]   byte_hits_c;
    logic               eval_c;
    logic [CNT_W-1:0]   cnt_byte_nx_c;
    logic [CNT_W-1:0]   cnt_occ_nx_c;

`ifdef PATCNT_CROSS_EN
    logic [PAT_W-2:0]          hist_q;
    logic                      first_q;
    logic [HIT_W-1:0]          str_hits_c;
    logic [BYTE_W+PAT_W-2:0]   stream_win_c;
    logic [CNT_W-1:0]          cnt_str_nx_c;
`endif

    // Clamp a full-width count to what fits in one memory word.
    function automatic logic [BYTE_W-1:0] sat(input logic [CNT_W-1:0] c);
        if ((c >> BYTE_W) != '0) return '1;
        return BYTE_W'(c);
    endfunction

    // MemRdData holds a string byte in every SCAN cycle after the pattern read, and in DRAIN.
    assign eval_c = ((state == SCAN) && (MemAddr != '0)) || (state == DRAIN);

    always_comb begin
        byte_hits_c = '0;
        for (int j = 0; j <= int'(BYTE_W - PAT_W); j++) begin
            if (MemRdData[j +: PAT_W] == pat_q) byte_hits_c = byte_hits_c + HIT_W'(1);
        end
    end

    assign cnt_byte_nx_c = CntByte + CNT_W'(byte_hits_c);
    assign cnt_occ_nx_c  = CntOcc + CNT_W'(byte_hits_c != '0);

`ifdef PATCNT_CROSS_EN
    // Older stream bits sit above the new byte, so each window ending in this byte is a plain slice.
    assign stream_win_c = {hist_q, MemRdData};

    always_comb begin
        str_hits_c = '0;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (stream_win_c[i +: PAT_W] == pat_q) str_hits_c = str_hits_c + HIT_W'(1);
        end
    end

    assign cnt_str_nx_c = CntStream + CNT_W'(first_q ? byte_hits_c : str_hits_c);
`else
    assign CntStream = '0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            Ack       <= 1'b0;
            Busy      <= 1'b0;
            MemAddr   <= '0;
            MemWrEn   <= 1'b0;
            MemWrData <= '0;
            CntByte   <= '0;
            CntOcc    <= '0;
            pat_q     <= '0;
`ifdef PATCNT_CROSS_EN
            CntStream <= '0;
            hist_q    <= '0;
            first_q   <= 1'b0;
`endif
        end else begin
            MemWrEn <= 1'b0;
            if (eval_c) begin
                CntByte <= cnt_byte_nx_c;
                CntOcc  <= cnt_occ_nx_c;
`ifdef PATCNT_CROSS_EN
                CntStream <= cnt_str_nx_c;
                hist_q    <= MemRdData[PAT_W-2:0];
                first_q   <= 1'b0;
`endif
            end
            case (state)
                IDLE, DONE: begin
                    if (Req) begin
                        state   <= RD_PAT;
                        Ack     <= 1'b0;
                        Busy    <= 1'b1;
                        MemAddr <= ADDR_W'(NUM_BYTES);
                        CntByte <= '0;
                        CntOcc  <= '0;
`ifdef PATCNT_CROSS_EN
                        CntStream <= '0;
                        hist_q    <= '0;
                        first_q   <= 1'b1;
`endif
                    end
                end
                RD_PAT: begin
                    state   <= SCAN;
                    MemAddr <= '0;
                end
                SCAN: begin
                    if (MemAddr == '0) pat_q <= MemRdData[BYTE_W-1 -: PAT_W];
                    if (MemAddr == ADDR_W'(NUM_BYTES - 1)) state <= DRAIN;
                    else MemAddr <= MemAddr + ADDR_W'(1);
                end
                DRAIN: begin
                    state     <= WR_BYTE;
                    MemWrEn   <= 1'b1;
                    MemAddr   <= ADDR_W'(NUM_BYTES + 1);
                    MemWrData <= sat(cnt_byte_nx_c);
                end
                WR_BYTE: begin
                    state     <= WR_OCC;
                    MemWrEn   <= 1'b1;
                    MemAddr   <= ADDR_W'(NUM_BYTES + 2);
                    MemWrData <= sat(CntOcc);
                end
`ifdef PATCNT_CROSS_EN
                WR_OCC: begin
                    state     <= WR_STR;
                    MemWrEn   <= 1'b1;
                    MemAddr   <= ADDR_W'(NUM_BYTES + 3);
                    MemWrData <= sat(CntStream);
                end
                WR_STR: begin
                    state <= DONE;
                    Ack   <= 1'b1;
                    Busy  <= 1'b0;
                end
`else
                WR_OCC: begin
                    state <= DONE;
                    Ack   <= 1'b1;
                    Busy  <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pattern_counter.md
PATTERN_COUNTER -- requirements
Module: pattern_counter

Interface
REQ-001 The block SHALL have parameter NUM_BYTES, default 32, giving the number of string bytes held at addresses 0..NUM_BYTES-1.
REQ-002 The block SHALL have parameter BYTE_W, default 8, giving the memory word width.
REQ-003 The block SHALL have parameter PAT_W, default 5, giving the pattern width, legal range 2..BYTE_W.
REQ-004 The block SHALL have derived widths ADDR_W = clog2(NUM_BYTES+4) and CNT_W = clog2(NUM_BYTES*BYTE_W+1).
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port Req, input, 1 bit: start request.
REQ-008 The block SHALL have port Ack, output, 1 bit: run complete, held high.
REQ-009 The block SHALL have port Busy, output, 1 bit: high while a run is in progress.
REQ-010 The block SHALL have port MemAddr, output, ADDR_W bits: the read/write address.
REQ-011 The block SHALL have port MemRdData, input, BYTE_W bits: synchronous read data, valid one cycle after MemAddr is presented.
REQ-012 The block SHALL have ports MemWrEn (output, 1 bit) and MemWrData (output, BYTE_W bits): the result write port.
REQ-013 The block SHALL have ports CntByte, CntOcc and CntStream, outputs, CNT_W bits each: full-width result counts.

Function
REQ-014 The FSM SHALL have states IDLE, RD_PAT, SCAN, DRAIN, WR_BYTE, WR_OCC, WR_STR and DONE.
REQ-015 In IDLE or DONE, sampling Req=1 SHALL clear the counters and Ack and enter RD_PAT with MemAddr=NUM_BYTES.
REQ-016 Req sampled in any other state SHALL be ignored.
REQ-017 The pattern SHALL be bits [BYTE_W-1:BYTE_W-PAT_W] of the word at address NUM_BYTES.
REQ-018 SCAN SHALL issue one read per cycle on addresses 0..NUM_BYTES-1, in order.
REQ-019 Each returned byte SHALL be evaluated in the cycle its data is valid.
REQ-020 DRAIN SHALL absorb the final read latency.
REQ-021 For each byte, windows [j+PAT_W-1:j] for j=0..BYTE_W-PAT_W SHALL be compared to the pattern.
REQ-022 CntByte SHALL increment by the number of matching windows in the byte.
REQ-023 CntOcc SHALL increment by 1 if at least one window matches.
REQ-024 Cross-byte counting SHALL treat the string as one bitstream, with byte 0 most significant and bit 7 of each byte first.
REQ-025 The block SHALL keep the last PAT_W-1 bits of the stream in a history register.
REQ-026 For byte 0, CntStream SHALL add the BYTE_W-PAT_W+1 windows lying wholly inside the byte.
REQ-027 For every later byte, CntStream SHALL add the BYTE_W windows ending in that byte.
REQ-028 The total number of stream windows SHALL be NUM_BYTES*BYTE_W-PAT_W+1.
REQ-029 WR_BYTE, WR_OCC and WR_STR SHALL each assert MemWrEn for one cycle, at addresses NUM_BYTES+1, +2 and +3 respectively.
REQ-030 Each written value SHALL be saturated to 2^BYTE_W-1 if the count exceeds it.
REQ-031 The Cnt* ports SHALL never saturate.
REQ-032 DONE SHALL hold Ack=1 and the Cnt* values until the next accepted Req.
REQ-033 Busy SHALL be 1 in all states except IDLE and DONE.
REQ-034 With the macro defined, Ack SHALL rise exactly NUM_BYTES+5 rising edges after the edge that samples Req.
REQ-035 MemWrEn SHALL be 0 in all states other than the write states.

Reset
REQ-036 Reset low SHALL immediately force state IDLE, with Ack=0, Busy=0, MemWrEn=0, MemAddr=0, MemWrData=0 and all Cnt*=0.
REQ-037 Reset low SHALL clear the pattern and history registers.
REQ-038 Reset asserted mid-run SHALL abort the run with no further memory writes.
REQ-039 After Reset is released, a new Req SHALL be required to start a run.

Configuration
REQ-040 The block SHALL use macro PATCNT_CROSS_EN.
REQ-041 With PATCNT_CROSS_EN defined, the history register, CntStream logic and the WR_STR state SHALL be present.
REQ-042 With PATCNT_CROSS_EN undefined, CntStream SHALL be tied to 0 and WR_STR removed.
REQ-043 With PATCNT_CROSS_EN undefined, address NUM_BYTES+3 SHALL never be written and Ack SHALL rise NUM_BYTES+4 edges after Req.

Verification
REQ-044 The bench SHALL cover: defaults, all bytes 0x00, pattern word 0x00 -> CntByte=128, CntOcc=32, CntStream=252, memory 33/34/35 = 128/32/252, Ack at edge 37.
REQ-045 The bench SHALL cover: defaults, all bytes 0x55, pattern word 0xA8 (10101) -> CntByte=64, CntOcc=32, CntStream=126.
REQ-046 The bench SHALL cover: defaults, all bytes 0x00, pattern word 0xF8 -> all counts 0, three writes of 0x00.
REQ-047 The bench SHALL cover: NUM_BYTES=64, all bytes 0x00, pattern 0x00 -> CntByte=256, CntStream=508 on ports, memory writes 255/64/255.
REQ-048 The bench SHALL cover: Reset low at cycle 10 of a run -> MemWrEn never asserts, Ack stays 0; the next Req gives correct counts.
REQ-049 The bench SHALL cover: Req re-pulsed during SCAN -> ignored, results identical to a single run, one Ack rise.
